serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor built from a BPC-bit full-adder slice plus one carry flop.
//  Processes one BPC-bit slice of the operands per clock, LSB slice first.
//  Trades latency for area against a flat WIDTH-bit adder.
//  Sits between valid/ready producer and consumer stages of the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 1
//  BPC    1  bits processed per clock; must be >= 1 and divide WIDTH exactly (other values illegal)
//  STEPS  (localparam) = WIDTH/BPC, number of compute cycles
// PORTS
//  clk        input   1      rising-edge clock
//  rst_n      input   1      asynchronous, active-low reset
//  in_valid   input   1      operands a/b/cin/sub presented
//  in_ready   output  1      block can accept operands (state IDLE)
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  cin        input   1      carry-in (add) / borrow-in (sub)
//  sub        input   1      0: a+b+cin; 1: a-b-cin
//  out_valid  output  1      result valid; held until out_ready
//  out_ready  input   1      consumer takes result
//  sum        output  WIDTH  result, modulo 2^WIDTH
//  cout       output  1      raw carry out of MSB (sub: 1 = no borrow)
//  overflow   output  1      two's-complement overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain.
//   - rst_n low asynchronously forces: state IDLE, out_valid=0, sum=0, cout=0, overflow=0, step count=0.
//   - in_ready=1 during and after reset.
//  FSM: IDLE -> CALC -> DONE -> IDLE
//   - IDLE: in_ready=1. On in_valid&&in_ready at edge E, register the operands and go to CALC.
//     - a loads as-is; b loads as (sub ? ~b : b).
//     - Carry flop loads (sub ? ~cin : cin).
//   - CALC: in_ready=0; inputs ignored.
//     - Each cycle, add the lowest BPC bits of A, B and the carry via a BPC-bit ripple of full adders.
//     - Shift A and B right by BPC.
//     - Shift the result register right by BPC; the new slice enters at bits [WIDTH-1:WIDTH-BPC].
//     - Carry flop takes the slice carry-out.
//     - The final step records carry-into-MSB for overflow.
//   - CALC -> DONE after exactly STEPS compute cycles; out_valid=1 from edge E+STEPS onward.
//   - DONE: sum/cout/overflow/out_valid hold stable while out_ready=0.
//     - out_valid&&out_ready at an edge: out_valid=0 and go to IDLE (in_ready=1 the next cycle).
//     - No overlap of acceptance with output; minimum issue interval STEPS+2 cycles.
//  Boundaries
//   - BPC==WIDTH: STEPS=1, out_valid at E+1.
//   - WIDTH==1: overflow = cin_eff XOR cout.
//   - sum/cout/overflow are undefined-but-stable (retain old values) outside DONE; consumers use only when out_valid=1.
//   - Reset asserted in CALC or DONE aborts the operation; no result is ever emitted for it.
//   - in_valid held high across DONE->IDLE is accepted in the first IDLE cycle.
// TESTING
//  T1 reset: assert rst_n=0 mid-CALC -> out_valid=0, sum=0, in_ready=1 immediately; no result after release.
//  T2 latency, WIDTH=8 BPC=1: a=0x0F b=0x01 cin=0 sub=0 -> sum=0x10 cout=0 overflow=0; out_valid exactly 8 edges after accept.
//  T3 add edges, WIDTH=8:
//   - a=0x7F b=0x01 -> sum=0x80 cout=0 overflow=1
//   - a=0xFF b=0x01 cin=1 -> sum=0x01 cout=1 overflow=0
//  T4 subtract, WIDTH=8:
//   - a=0x05 b=0x07 sub=1 -> sum=0xFE cout=0 overflow=0
//   - a=0x80 b=0x01 sub=1 -> sum=0x7F cout=1 overflow=1
//  T5 backpressure: hold out_ready=0 for 5 cycles in DONE while changing a/b and pulsing in_valid
//   - outputs stable, in_ready=0, nothing accepted
//   - release out_ready -> one transfer, then IDLE
//  T6 exhaustive, WIDTH=4, BPC in {1,2,4}: all a,b,cin,sub (1024 ops), random out_ready
//   - sum/cout/overflow match reference model
//   - latency = STEPS per op

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor. One BPC-bit ripple slice and a single carry
//   flop process the operands LSB slice first, STEPS = WIDTH/BPC cycles per
//   operation. Valid/ready handshake on both sides; one operation in flight.
//
//   Parameters
//     WIDTH  operand/result width (>= 1)
//     BPC    bits per clock (>= 1, must divide WIDTH exactly)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operands a/b/cin/sub presented
//     in_ready   block idle and able to accept operands
//     a, b       operands (WIDTH bits)
//     cin        carry-in for add, borrow-in for subtract
//     sub        0: a+b+cin   1: a-b-cin
//     out_valid  result valid, held until out_ready
//     out_ready  consumer takes the result
//     sum        result modulo 2^WIDTH
//     cout       raw carry out of the MSB (subtract: 1 = no borrow)
//     overflow   two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_last;
  logic [BPC-1:0]   w_slice;
  logic [BPC:0]     w_cvec;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;

  // One-bit full adder, returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic i_x, input logic i_y, input logic i_c);
    full_add = {(i_x & i_y) | (i_x & i_c) | (i_y & i_c), i_x ^ i_y ^ i_c};
  endfunction

  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_state == S_CALC) && (r_cnt == LAST_STEP);

  // Slice ripple adder plus the shifted operand registers for the next step.
  // The freed top bits of A collect the result slices, so after STEPS cycles
  // A holds the complete sum without a separate accumulator.
  always_comb begin
    w_cvec    = '0;
    w_slice   = '0;
    w_cvec[0] = r_carry;
    for (int i = 0; i < BPC; i++) begin
      {w_cvec[i+1], w_slice[i]} = full_add(r_a[i], r_b[i], w_cvec[i]);
    end
    w_a_nxt = r_a >> BPC;
    w_a_nxt[WIDTH-1 -: BPC] = w_slice;
    w_b_nxt = r_b >> BPC;
  end

  // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered handshake outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_in_ready  <= (w_state_nxt == S_IDLE);
    end
  end

  // Operand shift registers, carry flop and step counter.
  // Subtraction is a + ~b + ~cin, so the inversions are applied once at load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_carry <= w_cvec[BPC];
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

  // Result registers load only on the final step so they stay stable
  // between operations. The top slice bit is the MSB, so its carry-in is
  // the carry into the MSB used for overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_a_nxt;
      r_cout <= w_cvec[BPC];
      r_ovf  <= w_cvec[BPC] ^ w_cvec[BPC-1];
    end else begin
      r_sum  <= r_sum;
      r_cout <= r_cout;
      r_ovf  <= r_ovf;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Four serial_adder instances: WIDTH=8/BPC=1 for directed tests, and
//   WIDTH=4 with BPC 1, 2 and 4 for exhaustive randomized-handshake runs.
//   Each instance has an arithmetic reference model checked every cycle.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk;
  logic rst_n;
  logic t6_on;
  int   cyc;
  int   n_chk;
  int   n_fail;

  // instance 0 stimulus and observed outputs
  logic [7:0] a0, b0;
  logic       c0, s0, v0, r0;
  logic [7:0] o0_sum;
  logic       o0_ov, o0_ir, o0_co, o0_of;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {overflow, cout, sum[7:0]}.
  function automatic logic [9:0] ref_op(input int w, input int a, input int b, input int c, input int s);
    int   m, r, sa, sb, sr;
    logic co, of;
    m = (1 << w) - 1;
    if (s == 0) begin
      r  = a + b + c;
      co = (r > m);
    end else begin
      r  = a - b - c;
      co = (r >= 0);
    end
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = (s == 0) ? sa + sb + c : sa - sb - c;
    of = (sr > (m >> 1)) || (sr < -(1 << (w - 1)));
    return {of, co, 8'(r & m)};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int W    = (g == 0) ? 8 : 4;
    localparam int BP   = (g <= 1) ? 1 : ((g == 2) ? 2 : 4);
    localparam int ST   = W / BP;
    localparam int MASK = (1 << W) - 1;

    logic [7:0]   d_a, d_b;
    logic         d_c, d_s, d_v, d_r;
    logic [W-1:0] q_sum;
    logic         q_ir, q_ov, q_co, q_of;

    if (g == 0) begin : gen_dir
      assign d_a = a0;
      assign d_b = b0;
      assign d_c = c0;
      assign d_s = s0;
      assign d_v = v0;
      assign d_r = r0;
      assign o0_sum = 8'(q_sum);
      assign o0_ov  = q_ov;
      assign o0_ir  = q_ir;
      assign o0_co  = q_co;
      assign o0_of  = q_of;
    end else begin : gen_rnd
      logic [7:0] t_a, t_b;
      logic       t_c, t_s, t_v, t_r;
      logic       dn;
      assign d_a = t_a;
      assign d_b = t_b;
      assign d_c = t_c;
      assign d_s = t_s;
      assign d_v = t_v;
      assign d_r = t_r;

      // random consumer backpressure during the exhaustive run
      initial begin
        t_r = 1'b1;
        forever begin
          @(posedge clk);
          #1;
          if (t6_on) t_r = 1'($urandom_range(0, 1));
          else       t_r = 1'b1;
        end
      end

      // every a, b, cin, sub combination; in_valid stays high between ops
      initial begin
        int n;
        t_a = 8'h00; t_b = 8'h00; t_c = 1'b0; t_s = 1'b0; t_v = 1'b0; dn = 1'b0;
        wait (t6_on == 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 1024; k++) begin
          t_a = 8'(k & 15);
          t_b = 8'((k >> 4) & 15);
          t_c = 1'((k >> 8) & 1);
          t_s = 1'((k >> 9) & 1);
          t_v = 1'b1;
          n = 0;
          @(negedge clk);
          while (!q_ir && n < 200) begin
            @(negedge clk);
            n++;
          end
          chk($sformatf("u%0d_accept_bound", g), 32'(n < 200), 32'd1);
          @(posedge clk);
          #1;
        end
        t_v = 1'b0;
        dn  = 1'b1;
      end
    end

    serial_adder #(.WIDTH(W), .BPC(BP)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (d_v),
      .in_ready  (q_ir),
      .a         (d_a[W-1:0]),
      .b         (d_b[W-1:0]),
      .cin       (d_c),
      .sub       (d_s),
      .out_valid (q_ov),
      .out_ready (d_r),
      .sum       (q_sum),
      .cout      (q_co),
      .overflow  (q_of)
    );

    // Per-cycle compare against the model: one op in flight, result due
    // STEPS edges after the accepting edge, held until taken.
    bit         busy;
    int         due;
    logic [9:0] ex;
    initial begin
      busy = 1'b0;
      due  = 0;
      ex   = 10'd0;
    end
    always @(negedge clk) begin
      if (!rst_n) begin
        busy = 1'b0;
        chk($sformatf("u%0d_rst_out_valid", g), 32'(q_ov), 32'd0);
        chk($sformatf("u%0d_rst_in_ready", g), 32'(q_ir), 32'd1);
        chk($sformatf("u%0d_rst_sum", g), 32'(q_sum), 32'd0);
        chk($sformatf("u%0d_rst_cout", g), 32'(q_co), 32'd0);
        chk($sformatf("u%0d_rst_ovf", g), 32'(q_of), 32'd0);
      end else begin
        chk($sformatf("u%0d_out_valid", g), 32'(q_ov), 32'(busy && cyc >= due));
        chk($sformatf("u%0d_in_ready", g), 32'(q_ir), 32'(!busy));
        if (busy && cyc >= due) begin
          chk($sformatf("u%0d_sum", g), 32'(q_sum), 32'(ex[7:0]));
          chk($sformatf("u%0d_cout", g), 32'(q_co), 32'(ex[8]));
          chk($sformatf("u%0d_ovf", g), 32'(q_of), 32'(ex[9]));
          if (d_r) busy = 1'b0;
        end else if (!busy && d_v) begin
          busy = 1'b1;
          due  = cyc + 1 + ST;
          ex   = ref_op(W, int'(d_a) & MASK, int'(d_b) & MASK, int'(d_c), int'(d_s));
        end
      end
    end
  end

  // Directed operation on instance 0 with hand-computed expectations.
  task automatic op0(input string nm, input logic [7:0] a_i, input logic [7:0] b_i,
                     input logic c_i, input logic s_i,
                     input logic [7:0] es, input logic ec, input logic eo);
    int n;
    a0 = a_i; b0 = b_i; c0 = c_i; s0 = s_i; v0 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o0_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept_bound"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!o0_ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd8);
    chk({nm, "_sum"}, 32'(o0_sum), 32'(es));
    chk({nm, "_cout"}, 32'(o0_co), 32'(ec));
    chk({nm, "_ovf"}, 32'(o0_of), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] rx;
    logic [7:0] ra, rb;
    logic       rc, rs;
    bit         all_dn;
    n_chk = 0; n_fail = 0; t6_on = 1'b0;
    rst_n = 1'b1;
    a0 = 8'h00; b0 = 8'h00; c0 = 1'b0; s0 = 1'b0; v0 = 1'b0; r0 = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // latency and add edges
    op0("t2_0f_plus_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op0("t3_7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op0("t3_ff_plus_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    // subtract
    op0("t4_05_minus_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op0("t4_80_minus_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // reset in the middle of a computation
    a0 = 8'h22; b0 = 8'h11; c0 = 1'b0; s0 = 1'b0; v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid_now", 32'(o0_ov), 32'd0);
    chk("t1_sum_now", 32'(o0_sum), 32'd0);
    chk("t1_in_ready_now", 32'(o0_ir), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_no_result_after_reset", 32'(o0_ov), 32'd0);
    end
    @(posedge clk);
    #1;

    // backpressure in DONE
    r0 = 1'b0;
    op0("t5_3c_plus_25", 8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      v0 = 1'(i & 1);
      @(negedge clk);
      chk("t5_hold_out_valid", 32'(o0_ov), 32'd1);
      chk("t5_hold_in_ready", 32'(o0_ir), 32'd0);
      chk("t5_hold_sum", 32'(o0_sum), 32'h61);
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    r0 = 1'b1;
    @(negedge clk);
    chk("t5_before_release", 32'(o0_ov), 32'd1);
    @(negedge clk);
    chk("t5_after_release_valid", 32'(o0_ov), 32'd0);
    chk("t5_after_release_ready", 32'(o0_ir), 32'd1);
    @(posedge clk);
    #1;

    // random ops on the 8-bit instance
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rx = ref_op(8, int'(ra), int'(rb), int'(rc), int'(rs));
      op0("rand8", ra, rb, rc, rs, rx[7:0], rx[8], rx[9]);
    end

    // exhaustive 4-bit runs with random out_ready
    t6_on  = 1'b1;
    all_dn = 1'b0;
    for (int i = 0; i < 40000 && !all_dn; i++) begin
      @(posedge clk);
      all_dn = gen_dut[1].gen_rnd.dn && gen_dut[2].gen_rnd.dn && gen_dut[3].gen_rnd.dn;
    end
    chk("t6_all_ops_complete", 32'(all_dn), 32'd1);
    t6_on = 1'b0;
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
